// File: rtl/pipe_ctrl_multi_if.sv
// Bundle between the pipeline datapath and pipe_ctrl_multi.
//
// master: the datapath side; raises stall requests and exceptions,
//         receives the stall/bubble/flush controls and debug counters.
// slave : the control unit side.
//
// Signals:
//   stall_req     [NUM_REQ]     per-requester stall request (combinational)
//   exc_req                     exception/redirect request
//   exc_pc        [PC_W]        handler PC, qualified by exc_req
//   stall         [NUM_STAGES]  per-stage hold vector
//   bubble        [NUM_STAGES]  per-stage NOP insert vector
//   flush                       clear all pipeline registers
//   new_pc        [PC_W]        redirect PC, valid while flush = 1
//   stall_timeout               sticky stall watchdog flag
//   stall_cycles  [32]          saturating stalled-cycle count
interface pipe_ctrl_multi_if #(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned PC_W       = 32
);
    logic [NUM_REQ-1:0]    stall_req;
    logic                  exc_req;
    logic [PC_W-1:0]       exc_pc;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] bubble;
    logic                  flush;
    logic [PC_W-1:0]       new_pc;
    logic                  stall_timeout;
    logic [31:0]           stall_cycles;

    modport master (
        output stall_req, exc_req, exc_pc,
        input  stall, bubble, flush, new_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  stall_req, exc_req, exc_pc,
        output stall, bubble, flush, new_pc, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_multi.sv
// Pipeline control unit for the 5-stage CPU.
//
// - Merges per-requester stall requests into a stall (hold) vector and a
//   single-bit bubble vector. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM,
//   5 = WB. The deepest requesting stage H wins: stages 0..H hold, stage H+1
//   takes a bubble.
// - Sequences exception flushes (IDLE/FLUSH) and drives the redirect PC.
//   A new exception during a flush re-latches the PC and restarts the count.
// - Stall watchdog (sticky stall_timeout) and saturating stall-cycle counter.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  pipe_ctrl_multi_if.slave (see interface file for signal list)
module pipe_ctrl_multi #(
    parameter int unsigned          NUM_STAGES   = 6,
    parameter int unsigned          NUM_REQ      = 2,
    parameter logic [4*NUM_REQ-1:0] REQ_STAGE    = 8'h32,
    parameter int unsigned          FLUSH_CYCLES = 1,
    parameter int unsigned          MAX_STALL    = 64,
    parameter int unsigned          PC_W         = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_ctrl_multi_if.slave bus
);

    localparam int unsigned    ScntW    = $clog2(MAX_STALL);
    localparam logic [ScntW-1:0] ScntMax = ScntW'(MAX_STALL - 1);
    localparam logic [3:0]     FcntLoad = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e                state_q;
    logic                  flush_q;
    logic [3:0]            fcnt_q;
    logic [PC_W-1:0]       new_pc_q;
    logic [ScntW-1:0]      scnt_q;
    logic                  timeout_q;
    logic [31:0]           stall_cycles_q;

    logic [NUM_STAGES-1:0] merged;
    logic [NUM_STAGES-1:0] stall_v;
    logic [NUM_STAGES-1:0] bubble_v;
    logic                  stalling;

    // ------------------------------------------------------------------
    // Stall merge. Each requester owns a constant prefix mask (stages
    // 0..its stage). OR of prefix masks is the prefix mask of the deepest
    // active requester, so max-wins falls out of a plain OR chain.
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0] acc [NUM_REQ+1];
    assign acc[0] = '0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        localparam int unsigned RawStg = 32'(REQ_STAGE[4*g +: 4]);
        // Out-of-range stage indices saturate to the last stage.
        localparam int unsigned Stg    = (RawStg >= NUM_STAGES) ? NUM_STAGES - 1 : RawStg;
        localparam logic [NUM_STAGES-1:0] Mask =
            NUM_STAGES'((64'd1 << (Stg + 1)) - 64'd1);

        assign acc[g+1] = acc[g] | (bus.stall_req[g] ? Mask : '0);
    end

    assign merged = acc[NUM_REQ];

    // Flush and reset both override every stall request.
    assign stall_v  = (rst && !flush_q) ? merged : '0;
    // First stage above the held prefix gets the bubble; none if the prefix
    // already covers the top stage (the shift drops it).
    assign bubble_v = {stall_v[NUM_STAGES-2:0], 1'b0} & ~stall_v;
    assign stalling = |stall_v;

    // ------------------------------------------------------------------
    // Flush FSM, watchdog and stall-cycle counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            flush_q        <= 1'b0;
            fcnt_q         <= '0;
            new_pc_q       <= '0;
            scnt_q         <= '0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.exc_req) begin
                        state_q  <= StFlush;
                        flush_q  <= 1'b1;
                        new_pc_q <= bus.exc_pc;
                        fcnt_q   <= FcntLoad;
                    end
                end
                StFlush: begin
                    if (bus.exc_req) begin
                        // Latest exception wins and restarts the flush length.
                        new_pc_q <= bus.exc_pc;
                        fcnt_q   <= FcntLoad;
                    end else if (fcnt_q == '0) begin
                        state_q <= StIdle;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    flush_q <= 1'b0;
                end
            endcase

            // Consecutive-stall counter, saturating at MAX_STALL-1.
            if (flush_q || !stalling) begin
                scnt_q <= '0;
            end else if (scnt_q != ScntMax) begin
                scnt_q <= scnt_q + 1'b1;
            end

            // Sticky until a flush cycle; fires on the MAX_STALL-th stalled edge.
            if (flush_q) begin
                timeout_q <= 1'b0;
            end else if (stalling && scnt_q == ScntMax) begin
                timeout_q <= 1'b1;
            end

            if (stalling && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign bus.stall         = stall_v;
    assign bus.bubble        = bubble_v;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cycles  = stall_cycles_q;

endmodule

// File: doc/pipe_ctrl_multi.md
Name: pipe_ctrl_multi

Overview:
- Parametrised pipeline control unit for the 5-stage CPU.
- Merges any number of per-stage stall requests into a stall vector plus a bubble vector.
- Sequences exception flushes through a small state machine and drives the redirect PC to IF.
- Runs a stall watchdog and a saturating stall-cycle counter for debug and performance.

Parameters:
- NUM_STAGES, 6: width of the stall and bubble vectors. Bit 0 = PC, bit 1 = IF, bit 2 = ID, bit 3 = EX, bit 4 = MEM, bit 5 = WB.
- NUM_REQ, 2: number of stall requesters.
- REQ_STAGE, 8'h32: packed 4-bit stage indices, one per requester, requester r at bits [4r+3:4r]. Default: r0 (load) = 2, r1 (ex) = 3.
- FLUSH_CYCLES, 1: number of cycles flush stays high per exception, range 1..15.
- MAX_STALL, 64: consecutive stalled cycles before the watchdog fires, minimum 2.
- PC_W, 32: redirect PC width.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_req  in  NUM_REQ  one stall request per requester, combinational from its stage.
- exc_req  in  1  exception/redirect request, sampled on clk.
- exc_pc  in  PC_W  handler PC, qualified by exc_req.
- stall  out  NUM_STAGES  hold vector; bit k = 1 means stage k keeps its register.
- bubble  out  NUM_STAGES  bit k = 1 means stage k loads a NOP this cycle.
- flush  out  1  clears all pipeline registers.
- new_pc  out  PC_W  PC to load while flush = 1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  saturating count of cycles with stall != 0.

Behaviour:
- Reset (rst = 0, asynchronous): the following are forced immediately, independent of clk.
  - stall = 0, bubble = 0, flush = 0, new_pc = 0.
  - stall_timeout = 0, stall_cycles = 0, state = IDLE, internal counters = 0.
- Stall merge (combinational, zero latency):
  - Let H = the maximum REQ_STAGE[r] over all r with stall_req[r] = 1.
  - stall[k] = 1 for k <= H, else 0. This reproduces 'b111 for load and 'b1111 for ex.
  - bubble[H+1] = 1 if H+1 < NUM_STAGES; all other bubble bits are 0.
  - With no request active, stall = 0 and bubble = 0.
  - A REQ_STAGE entry >= NUM_STAGES saturates to NUM_STAGES-1, so all stall bits are set and there is no bubble.
- States: IDLE, FLUSH.
  - IDLE: if exc_req = 1 at an edge, go to FLUSH, latch new_pc <= exc_pc, and load fcnt <= FLUSH_CYCLES-1.
  - FLUSH: flush = 1.
    - If exc_req = 1 at an edge, re-latch new_pc and reload fcnt (latest exception wins; flush length restarts).
    - Else if fcnt = 0, go to IDLE.
    - Else fcnt decrements.
  - Flush latency: flush is high from the cycle after the exc_req edge, for exactly FLUSH_CYCLES cycles.
  - new_pc holds its last value in IDLE.
- Priority: while flush = 1, stall and bubble are forced to 0. Flush beats every stall request in the same cycle.
- Watchdog:
  - scnt increments on each edge where stall != 0; it clears on an edge where stall = 0 or flush = 1.
  - When scnt reaches MAX_STALL-1 with stall still != 0, stall_timeout is set at that edge.
  - stall_timeout stays set until reset or until a flush cycle.
  - scnt saturates at MAX_STALL-1.
- stall_cycles: increments on each edge where stall != 0, saturates at 32'hFFFFFFFF, cleared only by reset.
- Reset asserted mid-flush: flush drops immediately (asynchronous) and the state returns to IDLE.

Test Plan:
- stall_req = 2'b01, then 2'b10, then 2'b11 -> stall = 6'b000111 / bubble = 6'b001000; stall = 6'b001111 / bubble = 6'b010000; same as 6'b001111 (max wins). stall_req = 0 -> stall = 0, bubble = 0.
- exc_req pulse with exc_pc = 32'hBFC00380, FLUSH_CYCLES = 3 -> flush high for exactly cycles 1..3 after the edge; new_pc = 32'hBFC00380; state back in IDLE at cycle 4.
- exc_req pulse at the 2nd flush cycle with exc_pc = 32'h80000180 -> new_pc updates and flush extends to 3 cycles after the second edge.
- stall_req = 2'b10 held throughout an exception -> stall = 0 while flush = 1; stall = 6'b001111 again the cycle after flush drops.
- stall_req = 2'b01 held 64 cycles (MAX_STALL = 64) -> stall_timeout rises at the 64th stalled edge and stays high after the request drops; a subsequent flush clears it; stall_cycles = 64.
- rst driven low mid-flush, asynchronously between edges -> flush, new_pc, stall_timeout and stall_cycles all read 0 before the next clk edge.
